id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Decode stage of the 5-stage LA32R pipeline; consumes {inst,pc} from the fetch stage.
//  Holds the 32x32 register file and resolves branches, returning {br_taken,br_target}
//  to fetch. Forwards operands from EXE/MEM/WB, interlocks on load-use, and emits a
//  decoded bundle to EXE under a valid/allow handshake.
// PARAMETERS
//  RESET_PC  32'h1c000000  documentation only: first pc expected from fetch after reset
// PORTS
//  clk             in   1    clock
//  reset           in   1    synchronous, active-high
//  IF_to_ID_valid  in   1    fetch bundle valid
//  IF_to_ID_bus    in   64   {inst[63:32], pc[31:0]}
//  ID_allow        out  1    ID can accept a bundle this cycle
//  ID_to_IF_bus    out  33   {br_taken, br_target[31:0]}
//  EXE_allow       in   1    EXE can accept a bundle this cycle
//  ID_to_EXE_valid out  1    decoded bundle valid
//  ID_to_EXE_bus   out  148  {alu_op[11:0],src1,src2,rkd_value,mem_we,res_from_mem,gr_we,dest[4:0],pc}
//  EXE_fwd_bus     in   40   {valid,gr_we,is_load,dest[4:0],result[31:0]}
//  MEM_fwd_bus     in   39   {valid,gr_we,dest[4:0],result[31:0]} (load data already merged)
//  WB_to_RF_bus    in   38   {we,waddr[4:0],wdata[31:0]}
// BEHAVIOUR
//  - Regs: ID_valid, ID_inst, ID_pc. Reset: ID_valid=0, ID_inst=0, ID_pc=0.
//  - ID_allow = !ID_valid || (ID_ready_go && EXE_allow).
//  - Latch on ID_allow: ID_valid<=IF_to_ID_valid; if IF_to_ID_valid also capture inst/pc.
//  - ID_to_EXE_valid = ID_valid && ID_ready_go; ID_to_EXE_bus is combinational from
//    ID regs; it is don't-care while ID_to_EXE_valid=0.
//  - Decode: add.w sub.w slt sltu and or nor xor slli.w srli.w srai.w addi.w lu12i.w
//    ld.w st.w beq bne b bl jirl. Any other encoding decodes as NOP: gr_we=0, mem_we=0,
//    no branch.
//  - Immediates: si12 sign-extended; ui5 zero-extended; si20<<12 for lu12i.w;
//    offs16<<2 and offs26<<2 are sign-extended to 32 bits.
//  - dest: rd, except bl -> r1.
//  - gr_we=0 for st.w/beq/bne/b.
//  - src1=pc for bl/jirl; src2=4 for bl/jirl (link value).
//  - Regfile: 2 async read ports (rj; rk or rd). rd is read for st.w/beq/bne.
//    Write on WB we at posedge. r0 reads 0 and ignores writes.
//  - Forwarding per source, priority EXE > MEM > WB > regfile. A stage matches when
//    valid && gr_we && dest!=0 && dest==src reg. WB forwarding covers same-cycle
//    write/read.
//  - Load-use: a match on EXE with is_load=1 -> ID_ready_go=0 (stall).
//    MEM and WB matches never stall.
//  - Operands not used by the instruction (e.g. rk of addi.w) never stall.
//  - Branch: taken = beq&&(rj==rd) | bne&&(rj!=rd) | b | bl | jirl.
//  - Targets: pc+offs16 (beq/bne); pc+offs26 (b/bl); rj+offs16 (jirl).
//  - br_taken = ID_valid && ID_ready_go && taken. It is held while the branch waits on
//    EXE_allow; fetch re-targets each cycle, which is harmless.
//  - br_target = 0 when br_taken=0.
//  - Fetch drops its slot instruction on br_taken; ID never sees it.
//  - A stalled branch (load-use) keeps br_taken=0 until operands resolve.
//  - Arithmetic: all 32-bit wrap-around; no exceptions.
//  - Reset mid-stall or mid-branch clears ID_valid next edge; br_taken=0 in that cycle.
//    Regfile contents are not reset.
// TESTING
//  - addi.w r1,r0,5 then add.w r2,r1,r1 back-to-back -> EXE forward gives src1=src2=5;
//    no stall cycle.
//  - ld.w r3,r1,0 then add.w r4,r3,r0 -> 1 stall cycle (ID_allow=0, ID_to_EXE_valid=0),
//    then MEM forward supplies data.
//  - beq r0,r0,+8 at pc 0x1c000010 -> br_taken=1, br_target=0x1c000030 for 1 cycle
//    when EXE_allow=1.
//  - bl +0x100 at 0x1c000000 -> dest=1, src1=0x1c000000, src2=4,
//    br_target=0x1c000400; jirl r0,r1,0 with r1=0x1c000004 -> target 0x1c000004.
//  - WB writes r5=0xdeadbeef while ID reads r5 same cycle -> src1=0xdeadbeef;
//    write to r0 -> r0 still reads 0.
//  - EXE_allow=0 for 3 cycles with a valid bundle -> bundle held stable, ID_allow=0;
//    reset asserted -> ID_to_EXE_valid=0 next cycle.

Source files
------------

// File: rtl/id_stage.sv
// id_stage: LA32R decode stage with regfile, operand forwarding, load-use interlock and branch resolution
// Ports: clk/reset (sync, active-high); IF_to_ID_valid/IF_to_ID_bus {inst,pc} in, ID_allow out;
//   ID_to_IF_bus {br_taken,br_target} out; EXE_allow in, ID_to_EXE_valid/ID_to_EXE_bus out
//   {alu_op,src1,src2,rkd_value,mem_we,res_from_mem,gr_we,dest,pc};
//   EXE_fwd_bus {valid,gr_we,is_load,dest,result}, MEM_fwd_bus {valid,gr_we,dest,result},
//   WB_to_RF_bus {we,waddr,wdata} in.
module id_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         IF_to_ID_valid,
  input  logic [63:0]  IF_to_ID_bus,
  output logic         ID_allow,
  output logic [32:0]  ID_to_IF_bus,
  input  logic         EXE_allow,
  output logic         ID_to_EXE_valid,
  output logic [147:0] ID_to_EXE_bus,
  input  logic [39:0]  EXE_fwd_bus,
  input  logic [38:0]  MEM_fwd_bus,
  input  logic [37:0]  WB_to_RF_bus
);
  logic        id_valid, ready_go;
  logic [31:0] inst, pc;
  logic [31:0] rf [32];
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  assign {wb_we, wb_dest, wb_data} = WB_to_RF_bus;
  always_ff @(posedge clk)
    if (reset) begin
      id_valid <= 1'b0;
      inst <= '0;
      pc <= '0;
    end else if (ID_allow) begin
      id_valid <= IF_to_ID_valid;
      if (IF_to_ID_valid) {inst, pc} <= IF_to_ID_bus;
    end
  always_ff @(posedge clk)
    if (wb_we && wb_dest != 5'd0) rf[wb_dest] <= wb_data;
  logic [4:0] rd, rj, rk, r2;
  assign rd = inst[4:0];
  assign rj = inst[9:5];
  assign rk = inst[14:10];
  logic i_add, i_sub, i_slt, i_sltu, i_and, i_or, i_nor, i_xor, i_sll, i_srl, i_sra;
  logic i_addi, i_lui, i_ld, i_st, i_beq, i_bne, i_b, i_bl, i_jirl;
  assign i_add  = inst[31:15] == 17'h00020;
  assign i_sub  = inst[31:15] == 17'h00022;
  assign i_slt  = inst[31:15] == 17'h00024;
  assign i_sltu = inst[31:15] == 17'h00025;
  assign i_nor  = inst[31:15] == 17'h00028;
  assign i_and  = inst[31:15] == 17'h00029;
  assign i_or   = inst[31:15] == 17'h0002a;
  assign i_xor  = inst[31:15] == 17'h0002b;
  assign i_sll  = inst[31:15] == 17'h00081;
  assign i_srl  = inst[31:15] == 17'h00089;
  assign i_sra  = inst[31:15] == 17'h00091;
  assign i_addi = inst[31:22] == 10'h00a;
  assign i_ld   = inst[31:22] == 10'h0a2;
  assign i_st   = inst[31:22] == 10'h0a6;
  assign i_lui  = inst[31:25] == 7'b0001010;
  assign i_jirl = inst[31:26] == 6'h13;
  assign i_b    = inst[31:26] == 6'h14;
  assign i_bl   = inst[31:26] == 6'h15;
  assign i_beq  = inst[31:26] == 6'h16;
  assign i_bne  = inst[31:26] == 6'h17;
  logic alu3r, shimm, link, use_rj, use_r2;
  assign alu3r  = i_add | i_sub | i_slt | i_sltu | i_and | i_or | i_nor | i_xor;
  assign shimm  = i_sll | i_srl | i_sra;
  assign link   = i_bl | i_jirl;
  assign use_rj = alu3r | shimm | i_addi | i_ld | i_st | i_beq | i_bne | i_jirl;
  assign use_r2 = alu3r | i_st | i_beq | i_bne;
  assign r2     = (i_st | i_beq | i_bne) ? rd : rk;
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rfv,
                                      input logic [39:0] e, input logic [38:0] m, input logic [37:0] w);
    return r == 5'd0 ? 32'd0 :
           (e[39] && e[38] && e[36:32] == r) ? e[31:0] :
           (m[38] && m[37] && m[36:32] == r) ? m[31:0] :
           (w[37] && w[36:32] == r) ? w[31:0] : rfv;
  endfunction
  function automatic logic ld_hit(input logic [4:0] r, input logic [39:0] e);
    return r != 5'd0 && e[39] && e[38] && e[37] && e[36:32] == r;
  endfunction
  logic [31:0] rj_v, r2_v, si12, ui5, lui, offs16, offs26, src1, src2, target;
  assign rj_v   = fwd(rj, rf[rj], EXE_fwd_bus, MEM_fwd_bus, WB_to_RF_bus);
  assign r2_v   = fwd(r2, rf[r2], EXE_fwd_bus, MEM_fwd_bus, WB_to_RF_bus);
  assign ready_go = !((use_rj && ld_hit(rj, EXE_fwd_bus)) || (use_r2 && ld_hit(r2, EXE_fwd_bus)));
  assign si12   = {{20{inst[21]}}, inst[21:10]};
  assign ui5    = {27'd0, inst[14:10]};
  assign lui    = {inst[24:5], 12'd0};
  assign offs16 = {{14{inst[25]}}, inst[25:10], 2'b00};
  assign offs26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
  assign src1   = link ? pc : rj_v;
  assign src2   = (i_addi | i_ld | i_st) ? si12 : shimm ? ui5 : i_lui ? lui : link ? 32'd4 : r2_v;
  assign target = i_jirl ? rj_v + offs16 : (i_beq | i_bne) ? pc + offs16 : pc + offs26;
  logic [11:0] alu_op;
  logic        gr_we, taken, br_taken;
  assign alu_op = {i_lui, i_sra, i_srl, i_sll, i_xor, i_or, i_nor, i_and, i_sltu, i_slt, i_sub,
                   i_add | i_addi | i_ld | i_st | link};
  assign gr_we  = alu3r | shimm | i_addi | i_lui | i_ld | link;
  assign taken  = (i_beq && rj_v == r2_v) | (i_bne && rj_v != r2_v) | i_b | link;
  assign br_taken = !reset && id_valid && ready_go && taken;
  assign ID_to_IF_bus    = {br_taken, br_taken ? target : 32'd0};
  assign ID_allow        = !id_valid || (ready_go && EXE_allow);
  assign ID_to_EXE_valid = id_valid && ready_go;
  assign ID_to_EXE_bus   = {alu_op, src1, src2, r2_v, i_st, i_ld, gr_we, i_bl ? 5'd1 : rd, pc};
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage
module tb_id_stage;
  logic         clk = 1'b0, reset, IF_to_ID_valid, EXE_allow;
  logic [63:0]  IF_to_ID_bus;
  logic         ID_allow, ID_to_EXE_valid;
  logic [32:0]  ID_to_IF_bus;
  logic [147:0] ID_to_EXE_bus;
  logic [39:0]  EXE_fwd_bus;
  logic [38:0]  MEM_fwd_bus;
  logic [37:0]  WB_to_RF_bus;
  int tests = 0, fails = 0;
  id_stage dut (
    .clk(clk), .reset(reset), .IF_to_ID_valid(IF_to_ID_valid), .IF_to_ID_bus(IF_to_ID_bus),
    .ID_allow(ID_allow), .ID_to_IF_bus(ID_to_IF_bus), .EXE_allow(EXE_allow),
    .ID_to_EXE_valid(ID_to_EXE_valid), .ID_to_EXE_bus(ID_to_EXE_bus),
    .EXE_fwd_bus(EXE_fwd_bus), .MEM_fwd_bus(MEM_fwd_bus), .WB_to_RF_bus(WB_to_RF_bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [147:0] obs, input logic [147:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [31:0] i, input logic [31:0] p);
    IF_to_ID_valid = 1'b1;
    IF_to_ID_bus = {i, p};
    tick;
    IF_to_ID_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b1; IF_to_ID_valid = 1'b0; IF_to_ID_bus = '0; EXE_allow = 1'b1;
    EXE_fwd_bus = '0; MEM_fwd_bus = '0; WB_to_RF_bus = '0;
    repeat (2) tick;
    chk("rst_valid", ID_to_EXE_valid, 0);
    chk("rst_allow", ID_allow, 1);
    chk("rst_br", ID_to_IF_bus, 0);
    reset = 1'b0;
    WB_to_RF_bus = {1'b1, 5'd1, 32'h1c000004};
    tick;
    WB_to_RF_bus = '0;
    load(32'h02801401, 32'h1c000000);
    chk("addi_valid", ID_to_EXE_valid, 1);
    chk("addi_src1", ID_to_EXE_bus[135:104], 32'd0);
    chk("addi_src2", ID_to_EXE_bus[103:72], 32'd5);
    chk("addi_dest", ID_to_EXE_bus[36:32], 5'd1);
    chk("addi_grwe", ID_to_EXE_bus[37], 1);
    chk("addi_aluop", ID_to_EXE_bus[147:136], 12'h001);
    IF_to_ID_valid = 1'b1; IF_to_ID_bus = {32'h00100422, 32'h1c000004};
    EXE_fwd_bus = {1'b1, 1'b1, 1'b0, 5'd1, 32'd5};
    tick;
    IF_to_ID_valid = 1'b0;
    chk("exefwd_src1", ID_to_EXE_bus[135:104], 32'd5);
    chk("exefwd_src2", ID_to_EXE_bus[103:72], 32'd5);
    chk("exefwd_valid", ID_to_EXE_valid, 1);
    chk("exefwd_allow", ID_allow, 1);
    chk("add_dest", ID_to_EXE_bus[36:32], 5'd2);
    EXE_fwd_bus = '0;
    load(32'h28800023, 32'h1c000008);
    chk("ld_resmem", ID_to_EXE_bus[38], 1);
    chk("ld_src1_rf", ID_to_EXE_bus[135:104], 32'h1c000004);
    chk("ld_src2", ID_to_EXE_bus[103:72], 32'd0);
    IF_to_ID_valid = 1'b1; IF_to_ID_bus = {32'h00100064, 32'h1c00000c};
    EXE_fwd_bus = {1'b1, 1'b1, 1'b1, 5'd3, 32'h0};
    tick;
    IF_to_ID_valid = 1'b0;
    chk("lu_valid", ID_to_EXE_valid, 0);
    chk("lu_allow", ID_allow, 0);
    tick;
    EXE_fwd_bus = '0; MEM_fwd_bus = {1'b1, 1'b1, 5'd3, 32'h12345678};
    #1;
    chk("lu_rel_valid", ID_to_EXE_valid, 1);
    chk("lu_pc_held", ID_to_EXE_bus[31:0], 32'h1c00000c);
    chk("memfwd_src1", ID_to_EXE_bus[135:104], 32'h12345678);
    EXE_fwd_bus = {1'b1, 1'b1, 1'b0, 5'd3, 32'h0000aaaa};
    #1;
    chk("prio_exe", ID_to_EXE_bus[135:104], 32'h0000aaaa);
    EXE_fwd_bus = {1'b1, 1'b0, 1'b0, 5'd3, 32'h0000aaaa};
    #1;
    chk("exe_nowe", ID_to_EXE_bus[135:104], 32'h12345678);
    EXE_fwd_bus = '0; MEM_fwd_bus = '0;
    tick;
    load(32'h001000a6, 32'h1c000010);
    WB_to_RF_bus = {1'b1, 5'd5, 32'hdeadbeef};
    #1;
    chk("wbfwd_src1", ID_to_EXE_bus[135:104], 32'hdeadbeef);
    tick;
    WB_to_RF_bus = '0;
    #1;
    chk("rf_r5", ID_to_EXE_bus[135:104], 32'hdeadbeef);
    WB_to_RF_bus = {1'b1, 5'd0, 32'hffffffff};
    tick;
    WB_to_RF_bus = '0;
    load(32'h00100007, 32'h1c000014);
    chk("r0_rf", ID_to_EXE_bus[135:104], 32'd0);
    WB_to_RF_bus = {1'b1, 5'd0, 32'hffffffff};
    #1;
    chk("r0_wbfwd", ID_to_EXE_bus[103:72], 32'd0);
    WB_to_RF_bus = '0;
    EXE_fwd_bus = {1'b1, 1'b1, 1'b1, 5'd3, 32'h0};
    load(32'h02800c08, 32'h1c000018);
    chk("unused_nostall", ID_to_EXE_valid, 1);
    chk("addi_imm3", ID_to_EXE_bus[103:72], 32'd3);
    load(32'h58002060, 32'h1c000010);
    chk("brstall_br", ID_to_IF_bus, 0);
    chk("brstall_valid", ID_to_EXE_valid, 0);
    EXE_fwd_bus = '0; MEM_fwd_bus = {1'b1, 1'b1, 5'd3, 32'h0};
    #1;
    chk("brstall_rel", ID_to_IF_bus, {1'b1, 32'h1c000030});
    MEM_fwd_bus = '0;
    tick;
    load(32'h58002000, 32'h1c000010);
    chk("beq_br", ID_to_IF_bus, {1'b1, 32'h1c000030});
    chk("beq_grwe", ID_to_EXE_bus[37], 0);
    tick;
    chk("beq_once", ID_to_IF_bus, 0);
    load(32'h5bfff000, 32'h1c000010);
    chk("beq_neg", ID_to_IF_bus, {1'b1, 32'h1c000000});
    load(32'h5c002000, 32'h1c000010);
    chk("bne_nt", ID_to_IF_bus, 0);
    load(32'h54040000, 32'h1c000000);
    chk("bl_dest", ID_to_EXE_bus[36:32], 5'd1);
    chk("bl_src1", ID_to_EXE_bus[135:104], 32'h1c000000);
    chk("bl_src2", ID_to_EXE_bus[103:72], 32'd4);
    chk("bl_grwe", ID_to_EXE_bus[37], 1);
    chk("bl_br", ID_to_IF_bus, {1'b1, 32'h1c000400});
    load(32'h4c000020, 32'h1c000400);
    chk("jirl_br", ID_to_IF_bus, {1'b1, 32'h1c000004});
    chk("jirl_src1", ID_to_EXE_bus[135:104], 32'h1c000400);
    load(32'h29801025, 32'h1c000020);
    chk("st_memwe", ID_to_EXE_bus[39], 1);
    chk("st_grwe", ID_to_EXE_bus[37], 0);
    chk("st_rkd", ID_to_EXE_bus[71:40], 32'hdeadbeef);
    chk("st_src2", ID_to_EXE_bus[103:72], 32'd4);
    chk("st_src1", ID_to_EXE_bus[135:104], 32'h1c000004);
    load(32'h142468a9, 32'h1c000024);
    chk("lui_src2", ID_to_EXE_bus[103:72], 32'h12345000);
    chk("lui_aluop", ID_to_EXE_bus[147:136], 12'h800);
    load(32'h0040fc2a, 32'h1c000028);
    chk("slli_src2", ID_to_EXE_bus[103:72], 32'd31);
    chk("slli_aluop", ID_to_EXE_bus[147:136], 12'h100);
    load(32'hffffffff, 32'h1c00002c);
    chk("nop_grwe", ID_to_EXE_bus[37], 0);
    chk("nop_memwe", ID_to_EXE_bus[39], 0);
    chk("nop_br", ID_to_IF_bus, 0);
    tick;
    EXE_allow = 1'b0;
    IF_to_ID_valid = 1'b1; IF_to_ID_bus = {32'h58002000, 32'h1c000010};
    tick;
    IF_to_ID_bus = {32'hffffffff, 32'h1c000014};
    for (int i = 0; i < 3; i++) begin
      chk("hold_allow", ID_allow, 0);
      chk("hold_pc", ID_to_EXE_bus[31:0], 32'h1c000010);
      chk("hold_br", ID_to_IF_bus, {1'b1, 32'h1c000030});
      tick;
    end
    reset = 1'b1;
    tick;
    chk("rst_mid_valid", ID_to_EXE_valid, 0);
    chk("rst_mid_br", ID_to_IF_bus, 0);
    reset = 1'b0; IF_to_ID_valid = 1'b0; EXE_allow = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
